water_level_ctrl: RTL and testbench
===================================

Name: water_level_ctrl

Overview:
- Sequencer that drives the display/alarm block's `state[2:0]` and `btn7` inputs.
- Debounces the six thermometer-coded water-level probe switches and the raw acknowledge button.
- Holds the level code steady for a minimum time before committing it.
- Runs the alarm FSM (overflow or sensor fault), so the display block only ever sees clean, stable codes.

Parameters:
- DEB_CYCLES, 20, clk cycles an input must be stable before the debounced copy follows it.
- HOLD_CYCLES, 50, clk cycles an encoded level must persist before it is committed.
- ALARM_LEVEL, 6, committed level at or above which an overflow alarm is raised (range 1..6).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- level_sw  in  6  raw probe switches; bit i=1 means water at or above probe i; asynchronous to clk.
- btn_ack  in  1  raw acknowledge push-button, active-high, bouncy.
- state  out  3  code to display block: committed level 0..ALARM_LEVEL-1, or 3'b111 when alarming.
- btn7  out  1  one-cycle acknowledge pulse to display block.
- alarm  out  1  high while an alarm is unacknowledged.
- fault  out  1  high while the committed input is a non-thermometer code.
- level  out  3  committed level, 0..6, valid whenever fault=0.

Behaviour:
- Reset (async assert, sync release via rst_n):
  - state=0, btn7=0, alarm=0, fault=0, level=0.
  - Sync flops, debounce counters and hold counter = 0; FSM=NORMAL.
- Synchronisation: each of the 7 raw inputs passes through a 2-flop synchroniser.
- Debounce, per bit:
  - The counter increments while the synced value differs from the debounced value, and clears when they match.
  - When the counter reaches DEB_CYCLES-1, the debounced bit takes the synced value and the counter clears.
  - Latency from a clean edge = 2 + DEB_CYCLES cycles.
- Encoder, combinational on the debounced level_sw:
  - Valid codes are 000000, 000001, 000011, ... 111111; the level is the popcount (0..6).
  - Any other code gives valid=0 with level "don't care".
- Hold filter:
  - The candidate register holds {valid, level}.
  - If the encoder output differs from the candidate, the candidate is reloaded and the hold counter clears.
  - If it matches, the counter increments, saturating at HOLD_CYCLES-1.
  - On reaching HOLD_CYCLES-1, the candidate is copied to the committed {~fault, level}.
  - A glitch shorter than HOLD_CYCLES never reaches the committed value.
- Alarm condition `cond` = fault | (level >= ALARM_LEVEL), evaluated on committed values.
- Ack edge = debounced btn_ack 0->1 (registered previous value).
- FSM:
  - NORMAL: state=level. If cond, go to ALARM with alarm=1 registered on the same edge.
  - ALARM: state=3'b111, alarm=1. On ack edge: btn7=1 for exactly one cycle, alarm=0 next cycle, go to ACKED. Ack edges in NORMAL/ACKED are ignored (no btn7 pulse).
  - ACKED: state=3'b111, alarm=0. When cond drops, go to NORMAL. A renewed cond must pass through NORMAL before a new ALARM.
- Simultaneous ack edge and cond clearing in ALARM: ack wins (btn7 pulses, ACKED); NORMAL follows next cycle.
- cond clearing in ALARM without an ack: stay in ALARM (latched alarm).
- Reset mid-alarm: immediate return to reset values; the alarm is re-raised only after a full debounce and hold again.
- Counters sized $clog2 of their parameter; no wrap-around (saturate or clear as stated).

Decomposition:
- Shared package/header `water_pkg`:
  - FSM state encodings NORMAL=2'd0, ALARM=2'd1, ACKED=2'd2.
  - STATE_ALARM=3'b111.
  - Probe count NPROBE=6.
- One natural sub-module: `debounce` (param DEB_CYCLES; ports clk, rst_n, din, dout), including the synchroniser. Instantiated 7 times.

Test Plan (DEB_CYCLES=4, HOLD_CYCLES=8):
- Reset release, level_sw=000011 held -> state=2, level=2 after 2+4+8 cycles (±1 for registration); alarm=0.
- level_sw 000011->000111 for 5 cycles then back -> state stays 2; no change committed.
- level_sw=111111 -> level=6, state=3'b111, alarm=1. btn_ack pulse of 10 cycles -> btn7 high exactly 1 cycle, alarm=0, state remains 3'b111. level_sw=000111 -> state=3.
- level_sw=000101 -> fault=1, state=3'b111, alarm=1. Ack -> ACKED. Valid 000001 -> fault=0, state=1.
- btn_ack bouncing (1-cycle pulses every 2 cycles) in ALARM -> no btn7 until stable ≥4 cycles; then a single pulse.
- rst_n low mid-ALARM for 3 cycles -> all outputs 0 asynchronously. After release with level_sw=111111 -> alarm re-asserts after debounce+hold.

Source files
------------

// File: rtl/water_level_ctrl_pkg.sv
// Shared types and constants for the water-level sequencer.
package water_pkg;

  localparam int NPROBE = 6;

  // Display code shown while an alarm is active or acknowledged.
  localparam logic [2:0] STATE_ALARM = 3'b111;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    ALARM  = 2'd1,
    ACKED  = 2'd2
  } fsm_state_t;

  // Encoded probe reading; level is forced to 0 for invalid codes so that any
  // two invalid patterns compare equal in the hold filter.
  typedef struct packed {
    logic       valid;
    logic [2:0] level;
  } lvl_code_t;

  // Thermometer code 0..0 1..1 is valid exactly when code & (code+1) is zero.
  function automatic lvl_code_t thermo_encode(input logic [NPROBE-1:0] code);
    lvl_code_t        r;
    logic [NPROBE-1:0] plus1;
    plus1   = code + {{(NPROBE-1){1'b0}}, 1'b1};
    r.valid = ((code & plus1) == '0);
    r.level = '0;
    if (r.valid) begin
      for (int i = 0; i < NPROBE; i++) begin
        r.level = r.level + {2'b00, code[i]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/water_level_ctrl_debounce.sv
// Two-flop synchroniser followed by a consecutive-difference debounce counter.
module debounce
  import water_pkg::*;
#(
  parameter int DEB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          dout_q, dout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Bring the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  // Count cycles the synced value disagrees with the output; follow on the last one.
  always_comb begin
    dout_d = dout_q;
    cnt_d  = '0;
    if (sync2_q != dout_q) begin
      if (cnt_q == CNT_LAST) begin
        dout_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/water_level_ctrl.sv
// Water-level sequencer: debounced probes, level hold filter and alarm FSM
// producing clean state/btn7 codes for the display block.
//
//  state  | meaning
//  NORMAL | display shows committed level; raise alarm when cond is true
//  ALARM  | alarm latched (display 111) until an acknowledge edge
//  ACKED  | acknowledged, display 111; return to NORMAL once cond clears
module water_level_ctrl
  import water_pkg::*;
#(
  parameter int DEB_CYCLES  = 20,
  parameter int HOLD_CYCLES = 50,
  parameter int ALARM_LEVEL = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NPROBE-1:0] level_sw,
  input  logic              btn_ack,
  output logic [2:0]        state,
  output logic              btn7,
  output logic              alarm,
  output logic              fault,
  output logic [2:0]        level
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [2:0]    ALARM_LVL = 3'(ALARM_LEVEL);

  logic [NPROBE-1:0] sw_db;
  logic              ack_db;

  for (genvar i = 0; i < NPROBE; i++) begin : g_sw_deb
    debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (level_sw[i]),
      .dout  (sw_db[i])
    );
  end

  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ack_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (btn_ack),
    .dout  (ack_db)
  );

  lvl_code_t enc;
  lvl_code_t cand_q, cand_d;
  lvl_code_t commit_q, commit_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  assign enc = thermo_encode(sw_db);

  // Hold filter: a new code must stay unchanged for the full hold time before commit.
  always_comb begin
    cand_d     = cand_q;
    hold_cnt_d = hold_cnt_q;
    commit_d   = commit_q;
    if (enc != cand_q) begin
      cand_d     = enc;
      hold_cnt_d = '0;
    end else if (hold_cnt_q == HOLD_LAST) begin
      commit_d = cand_q;
    end else begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  // Hold filter registers; reset commits "valid, level 0".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q     <= '{valid: 1'b1, level: 3'd0};
      commit_q   <= '{valid: 1'b1, level: 3'd0};
      hold_cnt_q <= '0;
    end else begin
      cand_q     <= cand_d;
      commit_q   <= commit_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  logic cond;
  logic ack_prev_q;
  logic ack_edge;

  assign cond     = ~commit_q.valid | (commit_q.level >= ALARM_LVL);
  assign ack_edge = ack_db & ~ack_prev_q;

  // Remember the previous debounced acknowledge for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_prev_q <= 1'b0;
    end else begin
      ack_prev_q <= ack_db;
    end
  end

  fsm_state_t fsm_q, fsm_d;
  logic [2:0] state_q, state_d;
  logic       btn7_q, btn7_d;
  logic       alarm_q, alarm_d;

  // Alarm FSM next state; outputs are derived from the next state so they are registered.
  always_comb begin
    fsm_d  = fsm_q;
    btn7_d = 1'b0;
    case (fsm_q)
      NORMAL: if (cond) fsm_d = ALARM;
      ALARM: begin
        if (ack_edge) begin
          fsm_d  = ACKED;
          btn7_d = 1'b1;
        end
      end
      ACKED:  if (!cond) fsm_d = NORMAL;
      default: fsm_d = NORMAL;
    endcase
    alarm_d = (fsm_d == ALARM);
    state_d = (fsm_d == NORMAL) ? commit_q.level : STATE_ALARM;
  end

  // FSM state and display-facing output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= NORMAL;
      state_q <= 3'd0;
      btn7_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      btn7_q  <= btn7_d;
      alarm_q <= alarm_d;
    end
  end

  assign state = state_q;
  assign btn7  = btn7_q;
  assign alarm = alarm_q;
  assign fault = ~commit_q.valid;
  assign level = commit_q.level;

endmodule

// File: tb/tb_water_level_ctrl.sv
// Self-checking bench for water_level_ctrl with a run-length behavioural model.
module tb_water_level_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int ALVL = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] level_sw = 6'b000011;
  logic       btn_ack = 1'b0;
  logic [2:0] state;
  logic       btn7, alarm, fault;
  logic [2:0] level;

  water_level_ctrl #(
    .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .ALARM_LEVEL(ALVL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .level_sw(level_sw), .btn_ack(btn_ack),
    .state(state), .btn7(btn7), .alarm(alarm), .fault(fault), .level(level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int btn7_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Thermometer code -> level 0..6, or 7 for any non-thermometer pattern.
  function automatic int encode(input logic [5:0] code);
    for (int n = 0; n <= 6; n++) begin
      if (int'(code) == (1 << n) - 1) return n;
    end
    return 7;
  endfunction

  // Model: a signal follows its source once the source has held a new value long enough.
  int         cyc;
  logic [6:0] m_s1, m_s2, m_deb;
  int         m_s2_since[7];
  int         m_enc, m_enc_since;
  int         m_cvalid, m_clevel;
  logic       m_ack_prev;
  logic       m_in_alarm, m_in_acked;
  int         exp_state, exp_btn7, exp_alarm;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      cyc = 0;
      m_s1 = '0; m_s2 = '0; m_deb = '0;
      for (int b = 0; b < 7; b++) m_s2_since[b] = 0;
      m_enc = 0; m_enc_since = 0;
      m_cvalid = 1; m_clevel = 0;
      m_ack_prev = 1'b0;
      m_in_alarm = 1'b0; m_in_acked = 1'b0;
      exp_state = 0; exp_btn7 = 0; exp_alarm = 0;
    end else begin
      bit c, ack_rise;
      int new_enc;
      cyc++;
      c        = (m_cvalid == 0) || (m_clevel >= ALVL);
      ack_rise = m_deb[6] && !m_ack_prev;
      exp_btn7 = 0;
      if (m_in_alarm) begin
        if (ack_rise) begin
          m_in_alarm = 1'b0; m_in_acked = 1'b1; exp_btn7 = 1;
        end
      end else if (m_in_acked) begin
        if (!c) m_in_acked = 1'b0;
      end else if (c) begin
        m_in_alarm = 1'b1;
      end
      exp_alarm  = m_in_alarm;
      exp_state  = (m_in_alarm || m_in_acked) ? 7 : m_clevel;
      m_ack_prev = m_deb[6];
      // Candidate stage adds one cycle on top of the hold time.
      if (cyc - m_enc_since >= HOLD + 1) begin
        m_cvalid = (m_enc != 7);
        m_clevel = (m_enc == 7) ? 0 : m_enc;
      end
      for (int b = 0; b < 7; b++) begin
        if (m_s2[b] != m_deb[b] && (cyc - m_s2_since[b]) >= DEB) m_deb[b] = m_s2[b];
      end
      new_enc = encode(m_deb[5:0]);
      if (new_enc != m_enc) begin
        m_enc = new_enc;
        m_enc_since = cyc;
      end
      for (int b = 0; b < 7; b++) begin
        if (m_s2[b] != m_s1[b]) begin
          m_s2[b] = m_s1[b];
          m_s2_since[b] = cyc;
        end
      end
      m_s1 = {btn_ack, level_sw};
    end
  end

  // Compare every cycle against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("state", int'(state), exp_state);
    chk("btn7", int'(btn7), exp_btn7);
    chk("alarm", int'(alarm), exp_alarm);
    chk("fault", int'(fault), (m_cvalid == 0) ? 1 : 0);
    if (m_cvalid != 0) chk("level", int'(level), m_clevel);
    if (btn7) btn7_seen++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset with level 2 already on the probes.
    #2;
    chk("rst_state", int'(state), 0);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_level", int'(level), 0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(13);
    chk("lvl2_not_yet", int'(level), 0);
    wait_cyc(12);
    chk("lvl2_state", int'(state), 2);
    chk("lvl2_level", int'(level), 2);
    chk("lvl2_alarm", int'(alarm), 0);

    // Five-cycle excursion to level 3 must be filtered.
    level_sw = 6'b000111;
    wait_cyc(5);
    level_sw = 6'b000011;
    wait_cyc(30);
    chk("glitch_state", int'(state), 2);
    chk("glitch_level", int'(level), 2);

    // Overflow, acknowledge, then drop to level 3.
    level_sw = 6'b111111;
    wait_cyc(30);
    chk("ovf_level", int'(level), 6);
    chk("ovf_state", int'(state), 7);
    chk("ovf_alarm", int'(alarm), 1);
    btn7_seen = 0;
    btn_ack = 1'b1;
    wait_cyc(10);
    btn_ack = 1'b0;
    wait_cyc(15);
    chk("ack_pulses", btn7_seen, 1);
    chk("ack_alarm", int'(alarm), 0);
    chk("ack_state", int'(state), 7);
    level_sw = 6'b000111;
    wait_cyc(30);
    chk("lvl3_state", int'(state), 3);

    // Sensor fault, acknowledge, recovery to level 1.
    level_sw = 6'b000101;
    wait_cyc(30);
    chk("fault_flag", int'(fault), 1);
    chk("fault_state", int'(state), 7);
    chk("fault_alarm", int'(alarm), 1);
    btn_ack = 1'b1;
    wait_cyc(10);
    btn_ack = 1'b0;
    wait_cyc(15);
    chk("fault_ack_alarm", int'(alarm), 0);
    level_sw = 6'b000001;
    wait_cyc(30);
    chk("recover_fault", int'(fault), 0);
    chk("recover_state", int'(state), 1);

    // Bouncing acknowledge in ALARM produces no pulse until it settles.
    level_sw = 6'b111111;
    wait_cyc(30);
    chk("bounce_alarm", int'(alarm), 1);
    btn7_seen = 0;
    for (int i = 0; i < 6; i++) begin
      btn_ack = 1'b1;
      wait_cyc(1);
      btn_ack = 1'b0;
      wait_cyc(1);
    end
    wait_cyc(10);
    chk("bounce_no_pulse", btn7_seen, 0);
    chk("bounce_still_alarm", int'(alarm), 1);
    btn_ack = 1'b1;
    wait_cyc(10);
    btn_ack = 1'b0;
    wait_cyc(15);
    chk("settled_pulses", btn7_seen, 1);

    // Back through NORMAL into a fresh ALARM, then reset in the middle of it.
    level_sw = 6'b000011;
    wait_cyc(30);
    chk("renormal_state", int'(state), 2);
    level_sw = 6'b111111;
    wait_cyc(30);
    chk("realarm", int'(alarm), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_alarm", int'(alarm), 0);
    chk("async_level", int'(level), 0);
    chk("async_fault", int'(fault), 0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(10);
    chk("post_rst_quiet", int'(alarm), 0);
    wait_cyc(15);
    chk("post_rst_alarm", int'(alarm), 1);
    chk("post_rst_state", int'(state), 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
